count_ctrl: RTL

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl_pkg.sv | 20 ++
 rtl/count_ctrl_tmr.sv | 34 +++
 rtl/count_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types for count_ctrl: default data width, command opcodes and FSM states.
package count_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2,
        OP_READ = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/count_ctrl_tmr.sv
// Remaining-cycle down-counter for count_ctrl RUN phase; last_o flags the final cycle.
module count_ctrl_tmr #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] n_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = n_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: command sequencer driving an external loadable up/down counter.
// Defining COUNT_CTRL_ABORT_EN adds abort/aborted ports for early RUN termination.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    output logic             ctr_load,
    output logic             ctr_mode,
    output logic [CNT_W-1:0] ctr_data,
    input  logic [CNT_W-1:0] ctr_q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result
`ifdef COUNT_CTRL_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    state_e           state_q, state_d;
    op_e              op;
    logic [CNT_W-1:0] arg_q, arg_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             up_q, up_d;
    logic             tmr_load, tmr_dec, tmr_last;
    logic             abort_hit;

`ifdef COUNT_CTRL_ABORT_EN
    logic aborted_q, aborted_d;
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign op = op_e'(cmd_op);

    count_ctrl_tmr #(
        .CNT_W (CNT_W)
    ) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .n_i    (cmd_arg),
        .last_o (tmr_last)
    );

    always_comb begin
        state_d   = state_q;
        arg_d     = arg_q;
        up_d      = up_q;
        result_d  = result_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
`ifdef COUNT_CTRL_ABORT_EN
        aborted_d = aborted_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    arg_d = cmd_arg;
                    up_d  = (op == OP_UP);
`ifdef COUNT_CTRL_ABORT_EN
                    aborted_d = 1'b0;
`endif
                    case (op)
                        OP_LOAD: state_d = LOAD;
                        OP_UP, OP_DOWN: begin
                            // A zero step count skips RUN so the counter never moves.
                            if (cmd_arg != '0) begin
                                state_d  = RUN;
                                tmr_load = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
            LOAD: state_d = DONE;
            RUN: begin
                tmr_dec = 1'b1;
                if (tmr_last || abort_hit) begin
                    state_d = DONE;
`ifdef COUNT_CTRL_ABORT_EN
                    aborted_d = abort;
`endif
                end
            end
            DONE: begin
                result_d = ctr_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            arg_q     <= '0;
            up_q      <= 1'b0;
            result_q  <= '0;
`ifdef COUNT_CTRL_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            arg_q     <= arg_d;
            up_q      <= up_d;
            result_q  <= result_d;
`ifdef COUNT_CTRL_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // Outside RUN the counter reloads its own value, i.e. it is frozen.
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign ctr_load  = (state_q != RUN);
    assign ctr_mode  = (state_q == RUN) && up_q;
    assign ctr_data  = (state_q == LOAD) ? arg_q : ctr_q;
    assign result    = result_q;
`ifdef COUNT_CTRL_ABORT_EN
    assign aborted   = (state_q == DONE) && aborted_q;
`endif

`ifndef SYNTHESIS
    a_done_single: assert property (@(posedge clk) disable iff (!rst) done |=> !done);
`endif

endmodule
